// File: rtl/ex_mem_stage_if.sv
// EX->MEM handshake bundle: upstream accept side, downstream deliver side, and flush.
// The branch fields exist only when EX_MEM_BRANCH_EN is defined.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_out;
    logic              zero;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] m_alu_result;
    logic              m_zero;
    logic [DATA_W-1:0] m_store_data;
    logic [REG_AW-1:0] m_rd;
    logic              m_reg_write;
    logic              m_mem_read;
    logic              m_mem_write;
`ifdef EX_MEM_BRANCH_EN
    logic              branch;
    logic              m_branch_taken;
`endif

    // stage side
    modport slave (
        input  in_valid, alu_out, zero, store_data, rd, reg_write, mem_read, mem_write,
        input  flush, out_ready,
`ifdef EX_MEM_BRANCH_EN
        input  branch,
        output m_branch_taken,
`endif
        output in_ready, out_valid, m_alu_result, m_zero, m_store_data, m_rd,
        output m_reg_write, m_mem_read, m_mem_write
    );

    // environment side (EX producer + MEM consumer)
    modport master (
        output in_valid, alu_out, zero, store_data, rd, reg_write, mem_read, mem_write,
        output flush, out_ready,
`ifdef EX_MEM_BRANCH_EN
        output branch,
        input  m_branch_taken,
`endif
        input  in_ready, out_valid, m_alu_result, m_zero, m_store_data, m_rd,
        input  m_reg_write, m_mem_read, m_mem_write
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer so in_ready depends only on state.
// Optional branch-taken tracking is enabled by defining EX_MEM_BRANCH_EN.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_stage_if.slave ex_io
);
    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic              zero;
        logic [DATA_W-1:0] sdata;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
`ifdef EX_MEM_BRANCH_EN
        logic              branch;
`endif
    } payload_t;

    typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;

    state_t   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_pl;
    logic     accept, deliver, out_valid;

    always_comb begin
        in_pl           = '0;
        in_pl.alu       = ex_io.alu_out;
        in_pl.zero      = ex_io.zero;
        in_pl.sdata     = ex_io.store_data;
        in_pl.rd        = ex_io.rd;
        in_pl.reg_write = ex_io.reg_write;
        in_pl.mem_read  = ex_io.mem_read;
        in_pl.mem_write = ex_io.mem_write;
`ifdef EX_MEM_BRANCH_EN
        in_pl.branch    = ex_io.branch;
`endif
    end

    assign out_valid = (state_q != EMPTY);
    assign accept    = ex_io.in_valid & (state_q != FULL);
    assign deliver   = out_valid & ex_io.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: if (accept) begin
                state_d = HOLD;
                main_d  = in_pl;
            end
            HOLD: begin
                if (accept && deliver) begin
                    main_d = in_pl;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_pl;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (deliver) begin
                state_d = HOLD;
                main_d  = skid_q;
            end
            default: state_d = EMPTY;
        endcase
        // Flush only kills validity; stale data is masked by out_valid gating.
        if (ex_io.flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign ex_io.in_ready     = (state_q != FULL);
    assign ex_io.out_valid    = out_valid;
    assign ex_io.m_alu_result = main_q.alu;
    assign ex_io.m_zero       = main_q.zero;
    assign ex_io.m_store_data = main_q.sdata;
    assign ex_io.m_rd         = main_q.rd;
    assign ex_io.m_reg_write  = out_valid & main_q.reg_write;
    assign ex_io.m_mem_read   = out_valid & main_q.mem_read;
    assign ex_io.m_mem_write  = out_valid & main_q.mem_write;
`ifdef EX_MEM_BRANCH_EN
    assign ex_io.m_branch_taken = out_valid & main_q.branch & main_q.zero;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: reset, pass-through, skid/stall,
// flush, reset mid-stall, back-to-back streaming and (optionally) branch-taken.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ex_mem_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
    ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .ex_io(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] r, input logic rw, input logic mr,
                         input logic mw, input logic z);
        bus.in_valid   = v;
        bus.alu_out    = alu;
        bus.store_data = sd;
        bus.rd         = r;
        bus.reg_write  = rw;
        bus.mem_read   = mr;
        bus.mem_write  = mw;
        bus.zero       = z;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.m_alu_result !== 32'h0 || bus.m_store_data !== 32'h0 || bus.m_rd !== 5'd0 || bus.m_zero !== 1'b0) begin
            errors++; $display("FAIL reset_data got alu=%h sd=%h rd=%0d z=%b want 0", bus.m_alu_result, bus.m_store_data, bus.m_rd, bus.m_zero);
        end
        checks++; if ({bus.m_reg_write, bus.m_mem_read, bus.m_mem_write} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b want 000", {bus.m_reg_write, bus.m_mem_read, bus.m_mem_write});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000A310, 32'hDEAD0001, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.m_alu_result !== 32'h0000A310 || bus.m_rd !== 5'd5 || bus.m_reg_write !== 1'b1 || bus.m_store_data !== 32'hDEAD0001) begin
            errors++; $display("FAIL single_data got alu=%h rd=%0d rw=%b sd=%h want 0000a310 5 1 dead0001",
                               bus.m_alu_result, bus.m_rd, bus.m_reg_write, bus.m_store_data);
        end
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.m_reg_write !== 1'b0) begin
            errors++; $display("FAIL single_drain got valid=%b rw=%b want 0 0", bus.out_valid, bus.m_reg_write);
        end
    endtask

    task automatic test_skid();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (bus.in_ready !== 1'b1 || bus.m_alu_result !== 32'h1) begin
            errors++; $display("FAIL skid_hold got rdy=%b alu=%h want 1 1", bus.in_ready, bus.m_alu_result);
        end
        drive(1'b1, 32'h2, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b0 || bus.m_alu_result !== 32'h1 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL skid_full got rdy=%b alu=%h v=%b want 0 1 1", bus.in_ready, bus.m_alu_result, bus.out_valid);
        end
        step();
        checks++; if (bus.m_alu_result !== 32'h1 || bus.m_store_data !== 32'h11 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL skid_stall got alu=%h sd=%h rdy=%b want 1 11 0", bus.m_alu_result, bus.m_store_data, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.m_alu_result !== 32'h2 || bus.m_rd !== 5'd2 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL skid_second got v=%b alu=%h rd=%0d rdy=%b want 1 2 2 1", bus.out_valid, bus.m_alu_result, bus.m_rd, bus.in_ready);
        end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h30, 32'h300, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h40, 32'h400, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (bus.in_ready !== 1'b0 || bus.m_mem_write !== 1'b1) begin
            errors++; $display("FAIL flush_prefill got rdy=%b mw=%b want 0 1", bus.in_ready, bus.m_mem_write);
        end
        drive(1'b1, 32'h99, 32'h999, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.m_mem_write !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full got v=%b mw=%b rdy=%b want 0 0 1", bus.out_valid, bus.m_mem_write, bus.in_ready);
        end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_capture got %b want 0", bus.out_valid); end
        // flush beats a simultaneous accept while HOLD
        drive(1'b1, 32'h50, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        bus.flush = 1'b1;
        drive(1'b1, 32'h60, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.m_mem_read !== 1'b0 || bus.m_reg_write !== 1'b0) begin
            errors++; $display("FAIL flush_hold got v=%b mr=%b rw=%b want 0 0 0", bus.out_valid, bus.m_mem_read, bus.m_reg_write);
        end
    endtask

    task automatic test_reset_midstall();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h70, 32'h7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.m_alu_result !== 32'h0 || bus.m_mem_write !== 1'b0) begin
            errors++; $display("FAIL reset_midstall got v=%b rdy=%b alu=%h mw=%b want 0 1 0 0",
                               bus.out_valid, bus.in_ready, bus.m_alu_result, bus.m_mem_write);
        end
    endtask

    task automatic test_back_to_back();
        int bad_order = 0;
        int bad_ready = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h100 + k, 32'h200 + k, 5'(k + 8), 1'b1, 1'b0, 1'b0, 1'b0);
            step();
            if (bus.out_valid !== 1'b1 || bus.m_alu_result !== 32'h100 + k || bus.m_rd !== 5'(k + 8)) bad_order++;
            if (bus.in_ready !== 1'b1) bad_ready++;
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bad_order != 0) begin errors++; $display("FAIL b2b_order got %0d bad beats want 0", bad_order); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL b2b_in_ready got %0d low beats want 0", bad_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    endtask

`ifdef EX_MEM_BRANCH_EN
    task automatic test_branch();
        bus.out_ready = 1'b1;
        bus.branch = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bus.m_branch_taken !== 1'b1) begin errors++; $display("FAIL branch_taken got %b want 1", bus.m_branch_taken); end
        drive(1'b1, 32'h4, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (bus.m_branch_taken !== 1'b0) begin errors++; $display("FAIL branch_not_zero got %b want 0", bus.m_branch_taken); end
        bus.branch = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (bus.m_branch_taken !== 1'b0) begin errors++; $display("FAIL branch_idle got %b want 0", bus.m_branch_taken); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
`ifdef EX_MEM_BRANCH_EN
        bus.branch = 1'b0;
`endif
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_skid();
        test_flush();
        test_reset_midstall();
        test_back_to_back();
`ifdef EX_MEM_BRANCH_EN
        test_branch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
